opnd_sched: RTL
===============

OPND_SCHED -- requirements
Module: opnd_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of operand requesters sharing the datapath.
REQ-002 Parameter ITEM_WIDTH, default 8: width of each operand and of the result.
REQ-003 Parameter MAX_BURST, default 100: maximum operand pairs accepted per grant.
REQ-004 Parameter LATENCY, default 1: datapath cycles from operand launch to valid result.
REQ-005 clk_i  in  1  single clock; all logic on the rising edge.
REQ-006 reset_ni  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester operand pair valid.
REQ-008 req_a_i, req_b_i  in  NUM_REQ x ITEM_WIDTH each  per-requester operand A and operand B.
REQ-009 req_last_i  in  NUM_REQ  marks the final pair of the requester's burst.
REQ-010 req_ready_o  out  NUM_REQ  pair accepted when valid and ready are both high; at most one bit high.
REQ-011 A_s, B_s  out  ITEM_WIDTH each  registered operands to the datapath.
REQ-012 op_valid_o  out  1  A_s/B_s carry a new pair this cycle.
REQ-013 res_i  in  ITEM_WIDTH  datapath result.
REQ-014 res_valid_o, res_data_o, res_id_o  out  1 / ITEM_WIDTH / clog2(NUM_REQ)  tagged result stream.
REQ-015 done_o  out  NUM_REQ  one-cycle pulse per requester when its last result has been returned (xmit_en equivalent).

Function
REQ-016 FSM states: IDLE, BURST, DRAIN.
REQ-017 IDLE: if any req_valid_i is high, grant the first requester at or after rr_ptr in round-robin order, register it as gnt, and enter BURST next cycle; otherwise remain in IDLE.
REQ-018 BURST: req_ready_o[gnt]=1, all other ready bits 0; on handshake, A_s<=req_a_i[gnt], B_s<=req_b_i[gnt], op_valid_o<=1, cnt<=cnt+1; otherwise op_valid_o<=0 and A_s/B_s hold.
REQ-019 BURST exits to DRAIN on the handshake carrying req_last_i=1, or on the handshake making cnt equal MAX_BURST (truncation); ready drops in the following cycle.
REQ-020 When last and truncation coincide, the burst is treated as ended by last.
REQ-021 DRAIN lasts exactly LATENCY+1 cycles, then returns to IDLE with rr_ptr<=gnt+1 (modulo NUM_REQ) and cnt<=0.
REQ-022 On leaving DRAIN, done_o[gnt] pulses for one cycle only if the burst ended with last; truncated requesters re-arbitrate with no done pulse.
REQ-023 Result tagging: a LATENCY-deep shift line carries {op_valid, gnt}; res_valid_o/res_id_o are its output and res_data_o<=res_i, registered, so a result appears exactly LATENCY+1 cycles after its op_valid_o.
REQ-024 Results leave in launch order; no backpressure is applied on the result side.
REQ-025 cnt is clog2(MAX_BURST+1) bits wide and never wraps.
REQ-026 A requester dropping req_valid_i mid-burst stalls the grant; there is no timeout.
REQ-027 Requesters that are not granted are never accepted, so their inputs are don't-care.

Reset
REQ-028 Asserting reset_ni low immediately forces: state IDLE, rr_ptr=0, gnt=0, cnt=0, A_s=B_s=0, op_valid_o=0, all tag line stages invalid, res_valid_o=0, res_data_o=0, res_id_o=0, req_ready_o=0, done_o=0.
REQ-029 Reset asserted mid-burst discards in-flight results; no done pulse is produced.
REQ-030 The first arbitration after reset favours requester 0.

Structure
REQ-031 A shared package opnd_sched_pkg holds the FSM state enum, a tag struct {valid, id}, and default constants for NUM_REQ, ITEM_WIDTH, MAX_BURST and LATENCY.
REQ-032 One sub-module rr_arbiter (request vector and pointer in, one-hot grant plus index out, purely combinational) is instantiated once.

Verification
REQ-033 Single requester 0 sends 3 pairs (1,2),(3,4),(5,6) with last on the third, LATENCY=1: op_valid_o high for 3 cycles, res_id_o=0 three times, done_o[0] pulses once, FSM back in IDLE.
REQ-034 Requesters 0 and 2 both valid from reset, each with 2-pair bursts: 0 is served, then 2, then 0 again; no interleaving of res_id_o within a burst.
REQ-035 Requester 1 streams 150 pairs with last on pair 150, MAX_BURST=100: first grant is truncated at 100 with no done pulse; second grant carries 50 pairs; done_o[1] pulses once.
REQ-036 req_valid_i[3] drops for 5 cycles mid-burst: op_valid_o stays low for those 5 cycles, nothing is lost or duplicated, and the result count equals the pair count.
REQ-037 reset_ni is pulled low for one cycle with 2 results in flight: all outputs read 0 immediately, no res_valid_o follows, and the next grant goes to requester 0.
REQ-038 LATENCY=3 with a 4-pair burst: each result appears exactly 4 cycles after its op_valid_o, and done_o pulses after the fourth result.

Source files
------------

// File: rtl/opnd_sched_pkg.sv
// Shared types and default constants for the operand scheduler.
package opnd_sched_pkg;

    // Default parameter values used by the top level and the bench.
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ITEM_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 100;
    localparam int DEF_LATENCY    = 1;

    // Requester ids travel through the tag line in a fixed-width field;
    // the top level zero-extends into it and truncates on the way out.
    localparam int TAG_ID_W = 8;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // One stage of the result tag line.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Index width that stays legal for a single requester.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opnd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or
// after the pointer, wrapping around, and reports it one-hot and as index.
module rr_arbiter
    import opnd_sched_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [N-1:0]     gnt_onehot_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    // Scan from the pointer outward and take the first active request.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned, which would infer a latch.
        gnt_valid_o  = 1'b0;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        for (int off = 0; off < N; off++) begin
            if (!gnt_valid_o && req_i[(int'(ptr_i) + off) % N]) begin
                gnt_valid_o                               = 1'b1;
                gnt_onehot_o[(int'(ptr_i) + off) % N]     = 1'b1;
                gnt_idx_o                                 = IDX_W'((int'(ptr_i) + off) % N);
            end
        end
    end

endmodule

// File: rtl/opnd_sched.sv
// Operand scheduler: grants one requester at a time a burst of operand
// pairs into a shared fixed-latency datapath, tags the returning results
// with the requester id and signals burst completion.
module opnd_sched
    import opnd_sched_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int ITEM_WIDTH = DEF_ITEM_WIDTH,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    parameter  int LATENCY    = DEF_LATENCY,
    localparam int ID_W       = clog2_min1(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1),
    localparam int DRN_W      = $clog2(LATENCY + 2)
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][ITEM_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ-1:0][ITEM_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]                 req_last_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [ITEM_WIDTH-1:0]              A_s,
    output logic [ITEM_WIDTH-1:0]              B_s,
    output logic                               op_valid_o,
    input  logic [ITEM_WIDTH-1:0]              res_i,
    output logic                               res_valid_o,
    output logic [ITEM_WIDTH-1:0]              res_data_o,
    output logic [ID_W-1:0]                    res_id_o,
    output logic [NUM_REQ-1:0]                 done_o
);

    // FSM state
    state_e state_q, state_d;

    // Arbitration and burst bookkeeping
    logic [ID_W-1:0]    gnt_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DRN_W-1:0]   drain_q;
    logic               by_last_q;
    logic [NUM_REQ-1:0] done_q;

    // Operand launch registers
    logic [ITEM_WIDTH-1:0] a_q, b_q;
    logic                  op_valid_q;

    // Result tag line and registered result stream
    tag_t                  tag_q [LATENCY];
    logic                  res_valid_q;
    logic [ITEM_WIDTH-1:0] res_data_q;
    logic [ID_W-1:0]       res_id_q;

    // Decoded per-cycle controls
    logic hs;
    logic hit_last;
    logic hit_trunc;
    logic burst_end;
    logic drain_end;

    // Arbiter outputs
    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [ID_W-1:0]    arb_idx;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i        (req_valid_i),
        .ptr_i        (rr_ptr_q),
        .gnt_valid_o  (arb_valid),
        .gnt_onehot_o (arb_onehot),
        .gnt_idx_o    (arb_idx)
    );

    // The one-hot view is not needed here; the registered index drives the grant.
    logic unused_onehot;
    assign unused_onehot = ^arb_onehot;

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of its peers.
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, stream in BURST, wait out the pipe in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = BURST;
            BURST:   if (burst_end) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: ready for the granted requester only while bursting
    always_comb begin
        req_ready_o = '0;
        hs          = 1'b0;
        hit_last    = 1'b0;
        hit_trunc   = 1'b0;
        drain_end   = 1'b0;
        case (state_q)
            BURST: begin
                req_ready_o[gnt_q] = 1'b1;
                hs                 = req_valid_i[gnt_q];
                hit_last           = hs && req_last_i[gnt_q];
                // This handshake brings the count up to the burst limit.
                hit_trunc          = hs && (cnt_q == CNT_W'(MAX_BURST - 1));
            end
            DRAIN: begin
                drain_end = (drain_q == DRN_W'(LATENCY));
            end
            default: ;
        endcase
        burst_end = hit_last || hit_trunc;
    end

    // Grant, round-robin pointer, pair counter, drain timer and done pulse
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            drain_q   <= '0;
            by_last_q <= 1'b0;
            done_q    <= '0;
        end else begin
            done_q <= '0;
            if (state_q == IDLE && arb_valid) begin
                gnt_q <= arb_idx;
            end
            if (hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (burst_end) begin
                // A last that coincides with truncation still counts as a proper end.
                by_last_q <= hit_last;
                drain_q   <= '0;
            end else if (state_q == DRAIN) begin
                drain_q <= drain_q + 1'b1;
            end
            if (drain_end) begin
                rr_ptr_q <= (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                cnt_q    <= '0;
                drain_q  <= '0;
                if (by_last_q) begin
                    done_q[gnt_q] <= 1'b1;
                end
            end
        end
    end

    // Operand launch: capture the granted pair on handshake, otherwise hold
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_q        <= '0;
            b_q        <= '0;
            op_valid_q <= 1'b0;
        end else begin
            op_valid_q <= hs;
            if (hs) begin
                a_q <= req_a_i[gnt_q];
                b_q <= req_b_i[gnt_q];
            end
        end
    end

    // Tag line: carries {op_valid, gnt} alongside the datapath
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: every stage is cleared on reset; a stale valid bit here would surface as a phantom result.
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: op_valid_q, id: TAG_ID_W'(gnt_q)};
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Result register: pairs the returning datapath value with its tag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            res_valid_q <= tag_q[LATENCY-1].valid;
            res_id_q    <= tag_q[LATENCY-1].id[ID_W-1:0];
            res_data_q  <= res_i;
        end
    end

    assign A_s         = a_q;
    assign B_s         = b_q;
    assign op_valid_o  = op_valid_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
    assign done_o      = done_q;

endmodule
